calc_op_sequencer: RTL and testbench
====================================

// Module: calc_op_sequencer
// PURPOSE
//  Sequencing controller for the 4-bit switch calculator. Turns the active-low mode and
//  result buttons into clean one-cycle events and cycles the operating mode
//  (add/sub/mul/div). Latches both operands on a result request and runs the selected
//  operation: add/sub in one cycle, mul/div as 4-step shift-add / restoring iterations.
//  Drives the result, the mode LEDs and the alert LED consumed by the 7-segment display logic.
// PARAMETERS
//  W            4   operand width; mul/div iteration count = W; result width = 2*W
//  SYNC_STAGES  2   synchroniser flops per button input
// PORTS
//  clock        in   1    single system clock, all logic on rising edge
//  reset        in   1    synchronous, active-high; sole reset of all state
//  btn_modo_n   in   1    mode button, active-low, asynchronous
//  btn_res_n    in   1    result button, active-low, asynchronous
//  operand_a    in   W    switch bank 0 {switch_03..switch_00}
//  operand_b    in   W    switch bank 1 {switch_13..switch_10}
//  mode         out  2    0=add 1=sub 2=mul 3=div
//  led_modo     out  4    one-hot mode indicator, bit[mode]=1
//  busy         out  1    high from LATCH through last execute cycle
//  done         out  1    one-cycle pulse when result/led_alerta are updated
//  result       out  2W   add/sub/mul: value; div: {remainder[W-1:0], quotient[W-1:0]}
//  led_alerta   out  1    negative subtraction or divide by zero, for the last operation
// BEHAVIOUR
//  Reset: mode=0, led_modo=0001, result=0, led_alerta=0, busy=0, done=0, state=IDLE,
//   synchronisers preset to 1 (released). Reset mid-operation aborts it; no done is issued.
//  Buttons: SYNC_STAGES-flop sync, then falling-edge detect. mode_evt/res_evt are high for
//   one cycle, 2 clocks after the button is first sampled low. A held button gives one event.
//  States: IDLE -> LATCH -> EXEC -> DONE -> IDLE.
//   IDLE : res_evt -> LATCH. mode_evt alone -> mode=(mode+1) mod 4 (3 wraps to 0).
//          res_evt and mode_evt together: result request wins, the mode event is dropped.
//   LATCH: capture operand_a/b and the mode; busy=1; iteration counter=0.
//   EXEC : add/sub take 1 cycle. mul/div take W cycles (counter 0..W-1).
//   DONE : register result and led_alerta, done=1 for exactly this cycle, busy=0, -> IDLE.
//  Latency: done rises 3 cycles after res_evt for add/sub and W+2 (=6) cycles for mul/div.
//  Events while not in IDLE (busy or DONE) are discarded, not queued. Operand changes
//   after LATCH have no effect.
//  Arithmetic (unsigned):
//   add: a+b, zero-extended to 2W, max 30; alert=0.
//   sub: a>=b -> a-b, alert=0; a<b -> b-a (magnitude), alert=1.
//   mul: shift-add, multiplier LSB first, 2W accumulator; 15*15=225 fits; alert=0.
//   div: restoring, one quotient bit per cycle, MSB first.
//        b==0 -> result=0, alert=1; the W cycles still run so latency stays fixed.
//  result and led_alerta hold their values between done pulses.
//  led_modo updates in the cycle after mode changes.
// STRUCTURE
//  Shared header calc_defs.vh (package): MODE_ADD/SUB/MUL/DIV codes, state codes
//   (IDLE/LATCH/EXEC/DONE), default W. Also used by the display and top-level FSM.
//  Sub-module calc_btn_sync (synchroniser + falling-edge pulse), instantiated twice.
//  Datapath registers (accumulator, partial remainder, counter) stay inline in this module.
// TESTING
//  T1 reset, mode 0, a=12 b=4, press res -> result=16, alert=0, done 3 cycles after res_evt.
//  T2 1 mode press -> led_modo=0010. a=12 b=4 -> 8, alert 0. a=4 b=14 -> 10, alert 1.
//  T3 mode=2: a=12 b=4 -> 48; a=15 b=15 -> 225; done 6 cycles after res_evt, busy high 5 cycles.
//  T4 mode=3: a=12 b=5 -> 0x22 (q=2 r=2); a=12 b=4 -> 0x03; a=14 b=0 -> 0, alert=1.
//  T5 during mul: press mode and res -> ignored, mode stays 2, exactly one done.
//     Reset during div EXEC -> next cycle busy=0, result=0, mode=0, no done.
//  T6 4 mode presses from add -> back to 0001. Hold res 20 cycles -> one done only.
//     Simultaneous mode+res in IDLE -> op runs, mode unchanged.

Source files
------------

// File: rtl/calc_op_sequencer_pkg.sv
// Shared definitions for the switch calculator: operation codes, sequencer states
// and the default operand width.
package calc_op_sequencer_pkg;

    localparam int W_DEF = 4;

    typedef enum logic [1:0] {
        MODE_ADD = 2'd0,
        MODE_SUB = 2'd1,
        MODE_MUL = 2'd2,
        MODE_DIV = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic logic [3:0] mode_onehot(input logic [1:0] m);
        return 4'b0001 << m;
    endfunction

endpackage

// File: rtl/calc_op_sequencer_btn_sync.sv
// Button conditioner: multi-flop synchroniser for an active-low asynchronous input
// followed by a registered falling-edge detector giving a one-cycle press event.
module calc_btn_sync #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_n,
    output logic evt
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic              evt_q;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clock) begin
                    if (reset) sync_q[gi] <= 1'b1;
                    else       sync_q[gi] <= btn_n;
                end
            end else begin : g_rest
                always_ff @(posedge clock) begin
                    if (reset) sync_q[gi] <= 1'b1;
                    else       sync_q[gi] <= sync_q[gi-1];
                end
            end
        end
    endgenerate

    // Released level is 1, so a press is a 1 -> 0 transition of the synchronised signal.
    always_ff @(posedge clock) begin
        if (reset) begin
            prev_q <= 1'b1;
            evt_q  <= 1'b0;
        end else begin
            prev_q <= sync_q[STAGES-1];
            evt_q  <= prev_q & ~sync_q[STAGES-1];
        end
    end

    assign evt = evt_q;

endmodule

// File: rtl/calc_op_sequencer.sv
// Calculator sequencer: conditions the mode/result buttons, cycles the operating mode
// and runs add/sub in one cycle or mul/div as W-step shift-add / restoring iterations.
module calc_op_sequencer
    import calc_op_sequencer_pkg::*;
#(
    parameter int W           = W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             btn_modo_n,
    input  logic             btn_res_n,
    input  logic [W-1:0]     operand_a,
    input  logic [W-1:0]     operand_b,
    output logic [1:0]       mode,
    output logic [3:0]       led_modo,
    output logic             busy,
    output logic             done,
    output logic [2*W-1:0]   result,
    output logic             led_alerta
);

    localparam int RW = 2 * W;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    logic mode_evt;
    logic res_evt;

    calc_btn_sync #(.STAGES(SYNC_STAGES)) u_sync_modo (
        .clock (clock),
        .reset (reset),
        .btn_n (btn_modo_n),
        .evt   (mode_evt)
    );

    calc_btn_sync #(.STAGES(SYNC_STAGES)) u_sync_res (
        .clock (clock),
        .reset (reset),
        .btn_n (btn_res_n),
        .evt   (res_evt)
    );

    state_e          state_q, state_d;
    logic [1:0]      mode_q, mode_d;
    logic [3:0]      led_q;
    logic [1:0]      op_q, op_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [RW-1:0]   acc_q, acc_d;
    logic [RW-1:0]   mcand_q, mcand_d;
    logic [W-1:0]    mplr_q, mplr_d;
    logic [W-1:0]    rem_q, rem_d;
    logic [W-1:0]    quo_q, quo_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   result_q, result_d;
    logic            alert_q, alert_d;

    // One iteration of each multi-cycle operation, evaluated from the current registers.
    logic [RW-1:0]   mul_acc_step;
    logic [W:0]      div_shift;
    logic [W:0]      div_trial;
    logic            div_fits;
    logic [W-1:0]    div_rem_step;
    logic [W-1:0]    div_quo_step;
    logic            last_iter;

    always_comb begin
        mul_acc_step = mplr_q[0] ? (acc_q + mcand_q) : acc_q;
        div_shift    = {rem_q, quo_q[W-1]};
        div_trial    = div_shift - {1'b0, b_q};
        div_fits     = ~div_trial[W];
        div_rem_step = div_fits ? div_trial[W-1:0] : div_shift[W-1:0];
        div_quo_step = {quo_q[W-2:0], div_fits};
        last_iter    = (cnt_q == CW'(W - 1));
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplr_d   = mplr_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        alert_d  = alert_q;

        case (state_q)
            ST_IDLE: begin
                // A result request takes priority; a coincident mode press is dropped.
                if (res_evt) begin
                    state_d = ST_LATCH;
                end else if (mode_evt) begin
                    mode_d = mode_q + 2'd1;
                end
            end
            ST_LATCH: begin
                a_d     = operand_a;
                b_d     = operand_b;
                op_d    = mode_q;
                cnt_d   = '0;
                acc_d   = '0;
                mcand_d = RW'(operand_a);
                mplr_d  = operand_b;
                rem_d   = '0;
                quo_d   = operand_a;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                case (op_q)
                    MODE_ADD: begin
                        result_d = RW'(a_q) + RW'(b_q);
                        alert_d  = 1'b0;
                        state_d  = ST_DONE;
                    end
                    MODE_SUB: begin
                        if (a_q >= b_q) begin
                            result_d = RW'(a_q - b_q);
                            alert_d  = 1'b0;
                        end else begin
                            result_d = RW'(b_q - a_q);
                            alert_d  = 1'b1;
                        end
                        state_d = ST_DONE;
                    end
                    MODE_MUL: begin
                        acc_d   = mul_acc_step;
                        mcand_d = mcand_q << 1;
                        mplr_d  = mplr_q >> 1;
                        cnt_d   = cnt_q + 1'b1;
                        if (last_iter) begin
                            result_d = mul_acc_step;
                            alert_d  = 1'b0;
                            state_d  = ST_DONE;
                        end
                    end
                    default: begin
                        // Divide by zero still iterates so the latency never changes.
                        rem_d = div_rem_step;
                        quo_d = div_quo_step;
                        cnt_d = cnt_q + 1'b1;
                        if (last_iter) begin
                            if (b_q == '0) begin
                                result_d = '0;
                                alert_d  = 1'b1;
                            end else begin
                                result_d = {div_rem_step, div_quo_step};
                                alert_d  = 1'b0;
                            end
                            state_d = ST_DONE;
                        end
                    end
                endcase
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_ADD;
            led_q    <= 4'b0001;
            op_q     <= MODE_ADD;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplr_q   <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            alert_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            led_q    <= mode_onehot(mode_q);
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplr_q   <= mplr_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            alert_q  <= alert_d;
        end
    end

    assign mode       = mode_q;
    assign led_modo   = led_q;
    assign busy       = (state_q == ST_LATCH) || (state_q == ST_EXEC);
    assign done       = (state_q == ST_DONE);
    assign result     = result_q;
    assign led_alerta = alert_q;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Randomised self-checking bench for calc_op_sequencer against an arithmetic reference model.
module tb_calc_op_sequencer;

    localparam int W    = 4;
    localparam int SYNC = 2;
    // Negedges counted from the press edge until done is seen: sync + edge detect + op latency.
    localparam int LAT_ADDSUB = SYNC + 1 + 3;
    localparam int LAT_MULDIV = SYNC + 1 + W + 2;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           btn_modo_n = 1'b1;
    logic           btn_res_n = 1'b1;
    logic [W-1:0]   operand_a = '0;
    logic [W-1:0]   operand_b = '0;
    logic [1:0]     mode;
    logic [3:0]     led_modo;
    logic           busy;
    logic           done;
    logic [2*W-1:0] result;
    logic           led_alerta;

    int total = 0;
    int bad = 0;
    int exp_mode = 0;

    calc_op_sequencer #(.W(W), .SYNC_STAGES(SYNC)) dut (
        .clock      (clock),
        .reset      (reset),
        .btn_modo_n (btn_modo_n),
        .btn_res_n  (btn_res_n),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .mode       (mode),
        .led_modo   (led_modo),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .led_alerta (led_alerta)
    );

    always #5 clock = ~clock;

    function automatic void model(input int m, input int a, input int b,
                                  output int r, output int al);
        al = 0;
        case (m)
            0: r = a + b;
            1: begin
                if (a >= b) r = a - b;
                else begin r = b - a; al = 1; end
            end
            2: r = a * b;
            default: begin
                if (b == 0) begin r = 0; al = 1; end
                else r = (a % b) * 16 + (a / b);
            end
        endcase
    endfunction

    task automatic press_mode();
        @(negedge clock);
        btn_modo_n = 1'b0;
        repeat (4) @(negedge clock);
        btn_modo_n = 1'b1;
        repeat (4) @(negedge clock);
        exp_mode = (exp_mode + 1) % 4;
    endtask

    // Press result with the given operands; operands are scrambled once the op is latched.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                         input bit with_mode, output int res, output int alrt,
                         output int lat, output int busy_n, output int done_n,
                         output int res_end);
        @(negedge clock);
        operand_a = a;
        operand_b = b;
        btn_res_n = 1'b0;
        if (with_mode) btn_modo_n = 1'b0;
        lat = -1; busy_n = 0; done_n = 0; res = -1; alrt = -1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clock);
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (lat < 0) begin
                    lat = k;
                    res = int'(result);
                    alrt = int'(led_alerta);
                end
            end
            if (k == 5) begin
                operand_a = W'($urandom);
                operand_b = W'($urandom);
            end
            if (k == hold) begin
                btn_res_n = 1'b1;
                btn_modo_n = 1'b1;
            end
        end
        res_end = int'(result);
    endtask

    task automatic set_mode(input int m);
        while (exp_mode != m) press_mode();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        exp_mode = 0;
        total++;
        if (mode !== 2'd0 || led_modo !== 4'b0001 || busy !== 1'b0 || done !== 1'b0 ||
            result !== '0 || led_alerta !== 1'b0) begin
            bad++;
            $display("FAIL reset: mode=%0d led=%b busy=%b done=%b result=%0d alert=%b required 0 0001 0 0 0 0",
                     mode, led_modo, busy, done, result, led_alerta);
        end
    endtask

    task automatic check_op(input string name, input int m, input int a, input int b,
                            input int hold, input bit with_mode);
        int res, alrt, lat, busy_n, done_n, res_end, er, ea, el, eb;
        model(m, a, b, er, ea);
        el = (m < 2) ? LAT_ADDSUB : LAT_MULDIV;
        eb = (m < 2) ? 2 : W + 1;
        do_op(W'(a), W'(b), hold, with_mode, res, alrt, lat, busy_n, done_n, res_end);
        total++;
        if (res !== er || alrt !== ea || lat !== el || busy_n !== eb || done_n !== 1 ||
            res_end !== er) begin
            bad++;
            $display("FAIL %s: m=%0d a=%0d b=%0d got res=%0d alert=%0d lat=%0d busy=%0d dones=%0d hold=%0d required res=%0d alert=%0d lat=%0d busy=%0d dones=1",
                     name, m, a, b, res, alrt, lat, busy_n, done_n, res_end, er, ea, el, eb);
        end else begin
            $display("op %s: m=%0d a=%0d b=%0d res=%0d alert=%0d lat=%0d", name, m, a, b, res, alrt, lat);
        end
    endtask

    task automatic test_add();
        check_op("add_12_4", 0, 12, 4, 10, 1'b0);
        check_op("add_max", 0, 15, 15, 10, 1'b0);
    endtask

    task automatic test_sub();
        press_mode();
        total++;
        if (led_modo !== 4'b0010 || mode !== 2'd1) begin
            bad++;
            $display("FAIL led_sub: led=%b mode=%0d required 0010 1", led_modo, mode);
        end
        check_op("sub_12_4", 1, 12, 4, 10, 1'b0);
        check_op("sub_4_14", 1, 4, 14, 10, 1'b0);
        check_op("sub_eq", 1, 7, 7, 10, 1'b0);
    endtask

    task automatic test_mul();
        set_mode(2);
        check_op("mul_12_4", 2, 12, 4, 10, 1'b0);
        check_op("mul_15_15", 2, 15, 15, 10, 1'b0);
    endtask

    task automatic test_div();
        set_mode(3);
        check_op("div_12_5", 3, 12, 5, 10, 1'b0);
        check_op("div_12_4", 3, 12, 4, 10, 1'b0);
        check_op("div_14_0", 3, 14, 0, 10, 1'b0);
        check_op("div_15_1", 3, 15, 1, 10, 1'b0);
    endtask

    task automatic test_ignore_busy();
        int done_n, er, ea, res;
        set_mode(2);
        model(2, 9, 7, er, ea);
        done_n = 0; res = -1;
        @(negedge clock);
        operand_a = 4'd9; operand_b = 4'd7; btn_res_n = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clock);
            if (done) begin done_n++; res = int'(result); end
            if (k == 2) btn_res_n = 1'b1;
            if (k == 4) begin btn_res_n = 1'b0; btn_modo_n = 1'b0; end
            if (k == 12) begin btn_res_n = 1'b1; btn_modo_n = 1'b1; end
        end
        total++;
        if (done_n !== 1 || mode !== 2'd2 || res !== er) begin
            bad++;
            $display("FAIL ignore_busy: dones=%0d mode=%0d res=%0d required 1 2 %0d", done_n, mode, res, er);
        end
    endtask

    task automatic test_reset_mid_div();
        int done_n;
        set_mode(3);
        @(negedge clock);
        operand_a = 4'd13; operand_b = 4'd3; btn_res_n = 1'b0;
        repeat (6) @(negedge clock);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL div_busy_before_reset: busy=%b required 1", busy);
        end
        reset = 1'b1;
        btn_res_n = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        exp_mode = 0;
        total++;
        if (busy !== 1'b0 || result !== '0 || mode !== 2'd0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_div: busy=%b result=%0d mode=%0d done=%b required 0 0 0 0",
                     busy, result, mode, done);
        end
        done_n = 0;
        repeat (15) begin
            @(negedge clock);
            if (done) done_n++;
        end
        total++;
        if (done_n !== 0) begin
            bad++;
            $display("FAIL reset_no_done: dones=%0d required 0", done_n);
        end
    endtask

    task automatic test_mode_wrap();
        for (int i = 0; i < 4; i++) begin
            press_mode();
            total++;
            if (mode !== 2'(exp_mode) || led_modo !== (4'b0001 << exp_mode)) begin
                bad++;
                $display("FAIL mode_wrap_%0d: mode=%0d led=%b required %0d %b",
                         i, mode, led_modo, exp_mode, 4'b0001 << exp_mode);
            end
        end
    endtask

    task automatic test_hold_and_simul();
        check_op("hold_res_20", exp_mode, 5, 6, 20, 1'b0);
        check_op("simul_mode_res", exp_mode, 11, 3, 10, 1'b1);
        total++;
        if (mode !== 2'(exp_mode)) begin
            bad++;
            $display("FAIL simul_mode_kept: mode=%0d required %0d", mode, exp_mode);
        end
    endtask

    task automatic test_random();
        for (int m = 0; m < 4; m++) begin
            set_mode(m);
            for (int i = 0; i < 5; i++) begin
                check_op("rand", m, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 10, 1'b0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_div();
        test_ignore_busy();
        test_reset_mid_div();
        test_mode_wrap();
        test_hold_and_simul();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
